// File: rtl/regfile_wp_arbiter.sv
// regfile_wp_arbiter: round-robin arbiter for the register file write port, with a registered one-hot row select
module regfile_wp_arbiter #(
  parameter int NREQ = 4,
  parameter int DW   = 32,
  parameter int PW   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*5-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  input  logic              wr_stall,
  output logic              wr_en,
  output logic [4:0]        wr_addr,
  output logic [DW-1:0]     wr_data,
  output logic [31:0]       wr_sel,
  output logic [7:0]        drop_cnt
);
  logic [PW-1:0] ptr;
  logic          xfer;
  int            idx;
  int            gidx;
  logic [4:0]    ga;
  logic [DW-1:0] gd;
  always_comb begin
    req_ready = '0;
    xfer = 1'b0;
    gidx = 0;
    idx = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!rst && !wr_stall && !xfer && req_valid[idx]) begin
        xfer = 1'b1;
        gidx = idx;
        req_ready[idx] = 1'b1;
      end
    end
    ga = req_addr[gidx*5 +: 5];
    gd = req_data[gidx*DW +: DW];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr      <= '0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      wr_sel   <= '0;
      drop_cnt <= '0;
    end else if (!wr_stall) begin
      wr_en  <= 1'b0;
      wr_sel <= '0;
      if (xfer) begin
        ptr <= (gidx == NREQ - 1) ? '0 : PW'(gidx + 1);
        if (ga != 5'd0) begin
          wr_en   <= 1'b1;
          wr_addr <= ga;
          wr_data <= gd;
          wr_sel  <= 32'd1 << ga;
        end else begin
          wr_addr  <= '0;
          drop_cnt <= (drop_cnt == 8'hff) ? drop_cnt : drop_cnt + 8'd1;
        end
      end
    end
  end
endmodule

// File: tb/tb_regfile_wp_arbiter.sv
// tb_regfile_wp_arbiter: directed vectors against hand-computed expectations
module tb_regfile_wp_arbiter;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [3:0]   req_valid = '0;
  logic [19:0]  req_addr = '0;
  logic [127:0] req_data = '0;
  logic [3:0]   req_ready;
  logic         wr_stall = 1'b0;
  logic         wr_en;
  logic [4:0]   wr_addr;
  logic [31:0]  wr_data;
  logic [31:0]  wr_sel;
  logic [7:0]   drop_cnt;
  int n_cmp = 0;
  int n_bad = 0;
  regfile_wp_arbiter #(.NREQ(4), .DW(32), .PW(2)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
    .req_data(req_data), .req_ready(req_ready), .wr_stall(wr_stall),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_sel(wr_sel),
    .drop_cnt(drop_cnt)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic set_req(input int i, input logic [4:0] a, input logic [31:0] d);
    req_addr[i*5 +: 5] = a;
    req_data[i*32 +: 32] = d;
  endtask
  initial begin
    req_valid = 4'b1111;
    tick();
    #1;
    check("rst_ready", 64'(req_ready), 64'h0);
    check("rst_wr_en", 64'(wr_en), 64'h0);
    check("rst_wr_sel", 64'(wr_sel), 64'h0);
    check("rst_wr_addr", 64'(wr_addr), 64'h0);
    check("rst_wr_data", 64'(wr_data), 64'h0);
    check("rst_drop", 64'(drop_cnt), 64'h0);
    rst = 1'b0;
    req_valid = 4'b0001;
    set_req(0, 5'd5, 32'hDEADBEEF);
    #1;
    check("t1_ready", 64'(req_ready), 64'h1);
    tick();
    req_valid = '0;
    check("t1_wr_en", 64'(wr_en), 64'h1);
    check("t1_wr_addr", 64'(wr_addr), 64'd5);
    check("t1_wr_sel", 64'(wr_sel), 64'h20);
    check("t1_wr_data", 64'(wr_data), 64'hDEADBEEF);
    tick();
    check("t1_wr_en_off", 64'(wr_en), 64'h0);
    check("t1_wr_sel_off", 64'(wr_sel), 64'h0);
    check("t1_addr_hold", 64'(wr_addr), 64'd5);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) set_req(i, 5'(i + 1), 32'h100 + 32'(i));
    req_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      #1;
      check("rr_ready", 64'(req_ready), 64'(1) << (k % 4));
      tick();
      check("rr_wr_sel", 64'(wr_sel), 64'(1) << ((k % 4) + 1));
      check("rr_wr_data", 64'(wr_data), 64'h100 + 64'(k % 4));
    end
    req_valid = 4'b0010;
    #1;
    check("p_grant1", 64'(req_ready), 64'h2);
    tick();
    req_valid = 4'b0011;
    #1;
    check("p_wrap0", 64'(req_ready), 64'h1);
    tick();
    #1;
    check("p_next1", 64'(req_ready), 64'h2);
    tick();
    req_valid = 4'b1000;
    set_req(3, 5'd0, 32'h1234);
    #1;
    check("r0_ready", 64'(req_ready), 64'h8);
    tick();
    check("r0_wr_en", 64'(wr_en), 64'h0);
    check("r0_wr_sel", 64'(wr_sel), 64'h0);
    check("r0_wr_addr", 64'(wr_addr), 64'h0);
    check("r0_data_hold", 64'(wr_data), 64'h101);
    check("r0_drop1", 64'(drop_cnt), 64'd1);
    for (int k = 1; k < 300; k++) begin
      tick();
      if (k == 253) check("r0_drop254", 64'(drop_cnt), 64'd254);
    end
    check("r0_drop_sat", 64'(drop_cnt), 64'd255);
    req_valid = 4'b0001;
    set_req(0, 5'd7, 32'h77);
    set_req(1, 5'd2, 32'h22);
    #1;
    check("st_ready0", 64'(req_ready), 64'h1);
    tick();
    req_valid = 4'b0010;
    wr_stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("st_ready_off", 64'(req_ready), 64'h0);
      check("st_wr_en", 64'(wr_en), 64'h1);
      check("st_wr_addr", 64'(wr_addr), 64'd7);
      tick();
    end
    wr_stall = 1'b0;
    #1;
    check("st_hold_en", 64'(wr_en), 64'h1);
    check("st_hold_sel", 64'(wr_sel), 64'h80);
    check("st_ready1", 64'(req_ready), 64'h2);
    tick();
    req_valid = '0;
    check("st_next_addr", 64'(wr_addr), 64'd2);
    check("st_next_data", 64'(wr_data), 64'h22);
    check("st_next_sel", 64'(wr_sel), 64'h4);
    req_valid = 4'b0001;
    set_req(0, 5'd9, 32'h99);
    tick();
    req_valid = '0;
    check("rs_pend_sel", 64'(wr_sel), 64'h200);
    wr_stall = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    wr_stall = 1'b0;
    check("rs_wr_en", 64'(wr_en), 64'h0);
    check("rs_wr_sel", 64'(wr_sel), 64'h0);
    check("rs_drop", 64'(drop_cnt), 64'h0);
    req_valid = 4'b1111;
    #1;
    check("rs_ptr0", 64'(req_ready), 64'h1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/regfile_wp_arbiter.md
Name: regfile_wp_arbiter

Overview:
- Shares the register file's single write port between NREQ write-back requesters (ALU, load unit, multiplier, CSR path) using round-robin arbitration.
- Registers the winning write and drives the port's one-hot 32-entry write select directly, so the register file needs no separate address decoder on its write path.
- Writes to r0 are accepted from the requester but never reach the port.
- Sits between the execute/write-back stage and the register file.

Parameters:
- NREQ, 4, number of requesters (2..8).
- DW, 32, register data width.
- PW, 2, pointer width; must equal ceil(log2(NREQ)).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  requester i has a write pending.
- req_addr  in  NREQ*5  destination register; requester i in bits [i*5 +: 5].
- req_data  in  NREQ*DW  write data; requester i in bits [i*DW +: DW].
- req_ready  out  NREQ  grant; one-hot or zero.
- wr_stall  in  1  register file cannot take a write this cycle.
- wr_en  out  1  port write strobe.
- wr_addr  out  5  port address.
- wr_data  out  DW  port data.
- wr_sel  out  32  one-hot row select, bit wr_addr set when wr_en=1, else all zero.
- drop_cnt  out  8  saturating count of accepted writes to r0.

Behaviour:
- Reset (rst=1 at a clk edge):
  - wr_en=0, wr_addr=0, wr_data=0, wr_sel=0, drop_cnt=0.
  - Priority pointer ptr=0.
  - Reset overrides any same-cycle grant.
  - req_ready is forced to 0 while rst=1.
- Grant (combinational, within the cycle):
  - If wr_stall=0, scan requesters starting at ptr and wrapping modulo NREQ.
  - The first i with req_valid[i]=1 gets req_ready[i]=1; all other ready bits stay 0.
  - If wr_stall=1 or no requester is valid, req_ready=0.
- Transfer: happens on the edge where req_valid[i] & req_ready[i] are both 1.
- Pointer update:
  - On a transfer from requester i, ptr <= (i+1) mod NREQ.
  - With no transfer, ptr is unchanged.
  - Wrap: a grant to NREQ-1 sets ptr to 0.
- Output register, 1-cycle latency: on the transfer edge, with granted address a and data d:
  - If a != 0: wr_en<=1, wr_addr<=a, wr_data<=d, wr_sel<=(1<<a).
  - If a == 0: wr_en<=0, wr_sel<=0, wr_addr<=0; wr_data holds its previous value; drop_cnt<=drop_cnt+1, saturating at 255.
- No transfer, wr_stall=0: wr_en<=0, wr_sel<=0; wr_addr and wr_data hold.
- Stall:
  - While wr_stall=1, wr_en, wr_addr, wr_data and wr_sel all hold their values.
  - A pending write is therefore presented again on the cycle after the stall drops.
  - No new grant is issued during a stall.
- Each accepted write appears on the port for exactly one non-stalled cycle.
- Requester rules:
  - A requester must hold req_valid, addr and data stable until it sees ready.
  - It may deassert req_valid before being granted. Nothing is captured in that case and ptr does not move.
- Invariants:
  - popcount(req_ready) <= 1.
  - popcount(wr_sel) == wr_en.
  - wr_sel[0] is never 1.
- Fairness: with all requesters continuously valid, the grant order is ptr, ptr+1, … (mod NREQ), so each requester waits at most NREQ-1 non-stalled cycles.
- Reset mid-operation: any registered write that is pending or being held by a stall is discarded (wr_en=0 after reset). Requesters must re-present their writes.

Test Plan:
- Reset, then req_valid=4'b0001 with addr 5, data 0xDEADBEEF → req_ready=0001 in that cycle; next cycle wr_en=1, wr_addr=5, wr_sel=0x00000020, wr_data=0xDEADBEEF; the following cycle wr_en=0.
- req_valid=4'b1111 held for 8 cycles after reset, addrs 1..4 → grants in order 0,1,2,3,0,1,2,3; wr_sel sequence 0x2, 0x4, 0x8, 0x10, repeating.
- ptr=2 (after a grant to requester 1), req_valid=4'b0011 → requester 0 granted; next grant goes to requester 1.
- Requester 3 writes addr 0, data 0x1234 → req_ready[3]=1; next cycle wr_en=0, wr_sel=0, drop_cnt=1. After 300 such writes, drop_cnt=255.
- Transfer of addr 7, then wr_stall=1 for 3 cycles with requester 1 valid → wr_en=1, wr_addr=7 held for all 3 cycles; req_ready=0 throughout; 1 cycle after wr_stall falls requester 1 is granted, and its write appears on the port one cycle after that.
- Assert rst for one cycle while wr_stall=1 holds a pending write to addr 9 → the next cycle shows wr_en=0, wr_sel=0, ptr=0, drop_cnt=0.
